// File: rtl/bcd_scan_display.sv
// Multiplexed 7-segment scanner for N_DIGITS packed-BCD digits, with leading-zero blanking and decimal points.
// Latency: seg_out/dig_sel are registered one cycle after the scan index; frame_done is registered on the wrap edge.
// Backpressure: none; enable=0 freezes the scan and blanks the outputs, and load is always accepted.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   enable              scan enable (0 = blank + freeze)
//   load                capture strobe for bcd_in / dp_in
//   bcd_in, dp_in       packed BCD digits (digit 0 = LSB nibble) and per-digit decimal points
//   seg_out             {dp, a, b, c, d, e, f, g}
//   dig_sel             one-hot digit enable (bit i = digit i)
//   frame_done          one-cycle pulse when the scan wraps back to digit 0
module bcd_scan_display #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 0,
    parameter int BLANK_LZ    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    output logic [7:0]              seg_out,
    output logic [N_DIGITS-1:0]     dig_sel,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [7:0]          SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] DIG_OFF  = (ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
    logic [N_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*N_DIGITS-1:0] disp_bcd_q, disp_bcd_d;
    logic [N_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [7:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   dig_q, dig_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tick;
    logic                  frame_tick;
    logic [N_DIGITS-1:0]   blank;
    logic                  zero_run;
    logic [3:0]            nib_sel;
    logic                  dp_sel;
    logic                  blk_sel;
    logic [N_DIGITS-1:0]   dig_onehot;
    logic [7:0]            seg_lit;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h7E;
            4'd1:    s = 7'h30;
            4'd2:    s = 7'h6D;
            4'd3:    s = 7'h79;
            4'd4:    s = 7'h33;
            4'd5:    s = 7'h5B;
            4'd6:    s = 7'h5F;
            4'd7:    s = 7'h72;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h73;
            default: s = 7'h4F; // non-BCD nibbles show 'E'
        endcase
        return s;
    endfunction

    assign tick       = enable && (cnt_q == CNT_LAST);
    assign frame_tick = tick && (idx_q == IDX_LAST);

    // Leading-zero mask: walk down from the top digit while everything seen so far is zero.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (disp_bcd_q[4*i +: 4] == 4'd0);
            blank[i] = (BLANK_LZ != 0) && (i != 0) && zero_run;
        end
    end

    always_comb begin
        nib_sel    = '0;
        dp_sel     = 1'b0;
        blk_sel    = 1'b0;
        dig_onehot = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_sel       = disp_bcd_q[4*i +: 4];
                dp_sel        = disp_dp_q[i];
                blk_sel       = blank[i];
                dig_onehot[i] = 1'b1;
            end
        end
    end

    assign seg_lit = {dp_sel, blk_sel ? 7'h00 : decode(nib_sel)};

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_bcd_d = shadow_bcd_q;
        shadow_dp_d  = shadow_dp_q;
        disp_bcd_d   = disp_bcd_q;
        disp_dp_d    = disp_dp_q;
        seg_d        = SEG_OFF;
        dig_d        = DIG_OFF;
        frame_done_d = frame_tick;

        if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            seg_d = (ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
            dig_d = (ACTIVE_LOW != 0) ? ~dig_onehot : dig_onehot;
        end
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        if (load) begin
            shadow_bcd_d = bcd_in;
            shadow_dp_d  = dp_in;
        end
        // A load landing on the wrap edge bypasses the shadow so the new value is not a frame late.
        if (frame_tick) begin
            disp_bcd_d = load ? bcd_in : shadow_bcd_q;
            disp_dp_d  = load ? dp_in  : shadow_dp_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_bcd_q <= '0;
            shadow_dp_q  <= '0;
            disp_bcd_q   <= '0;
            disp_dp_q    <= '0;
            seg_q        <= SEG_OFF;
            dig_q        <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_bcd_q <= shadow_bcd_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_bcd_q   <= disp_bcd_d;
            disp_dp_q    <= disp_dp_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_sel    = dig_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
module tb_bcd_scan_display;

    localparam int ND  = 4;
    localparam int DIV = 4;
    localparam int FRAME = ND * DIV;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [7:0]  seg_out, seg_al;
    logic [3:0]  dig_sel, dig_al;
    logic        frame_done, fd_al;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: enabled edges since reset, value on display, last loaded value.
    int          m_e;
    logic [15:0] m_shown, m_latest;
    logic [3:0]  m_shown_dp, m_latest_dp;

    logic [6:0] seg_tbl [0:15] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h72,
                                   7'h7F, 7'h73, 7'h4F, 7'h4F, 7'h4F, 7'h4F, 7'h4F, 7'h4F};

    bcd_scan_display #(.N_DIGITS(ND), .REFRESH_DIV(DIV), .ACTIVE_LOW(0), .BLANK_LZ(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
        .seg_out(seg_out), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    bcd_scan_display #(.N_DIGITS(ND), .REFRESH_DIV(DIV), .ACTIVE_LOW(1), .BLANK_LZ(1)) u_dut_al (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
        .seg_out(seg_al), .dig_sel(dig_al), .frame_done(fd_al)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_e         = 0;
        m_shown     = '0;
        m_latest    = '0;
        m_shown_dp  = '0;
        m_latest_dp = '0;
    endtask

    // Drives one cycle of stimulus and returns what the outputs must be just after the edge.
    task automatic cyc(input logic en, input logic ld, input logic [15:0] bcd, input logic [3:0] dp,
                       output logic [7:0] es, output logic [3:0] ed, output logic ef);
        int d;
        logic [3:0] nib;
        @(negedge clk);
        enable = en;
        load   = ld;
        bcd_in = bcd;
        dp_in  = dp;
        es = '0;
        ed = '0;
        ef = 1'b0;
        if (en) begin
            d   = (m_e / DIV) % ND;
            nib = 4'((m_shown >> (4 * d)) & 16'hF);
            es[6:0] = (d > 0 && (m_shown >> (4 * d)) == 16'h0) ? 7'h00 : seg_tbl[nib];
            es[7]   = m_shown_dp[d];
            ed      = 4'(1 << d);
            m_e++;
            ef = (m_e % FRAME) == 0;
        end
        if (ld) begin
            m_latest    = bcd;
            m_latest_dp = dp;
        end
        if (ef) begin
            m_shown    = m_latest;
            m_shown_dp = m_latest_dp;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        bcd_in = '0;
        dp_in  = '0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (seg_out !== 8'h00 || dig_sel !== 4'h0 || frame_done !== 1'b0 ||
            seg_al !== 8'hFF || dig_al !== 4'hF || fd_al !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got seg=%h dig=%b fd=%b al_seg=%h al_dig=%b, want 00 0000 0 FF 1111",
                     seg_out, dig_sel, frame_done, seg_al, dig_al);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_check(input string name, input int ncyc, input logic ld0,
                             input logic [15:0] bcd, input logic [3:0] dp);
        logic [7:0] es;
        logic [3:0] ed;
        logic ef;
        for (int k = 0; k < ncyc; k++) begin
            cyc(1'b1, (k == 0) ? ld0 : 1'b0, bcd, dp, es, ed, ef);
            n_vec++;
            if (seg_out !== es || dig_sel !== ed || frame_done !== ef ||
                seg_al !== ~es || dig_al !== ~ed || fd_al !== ef) begin
                n_err++;
                $display("FAIL %s cyc %0d: got seg=%h dig=%b fd=%b al=%h/%b, want seg=%h dig=%b fd=%b",
                         name, k, seg_out, dig_sel, frame_done, seg_al, dig_al, es, ed, ef);
            end
        end
    endtask

    task automatic test_basic();
        run_check("basic_1234", 3 * FRAME, 1'b1, 16'h1234, 4'b0000);
    endtask

    task automatic test_patterns();
        run_check("pat_0070", 2 * FRAME + 2, 1'b1, 16'h0070, 4'b0000);
        run_check("pat_0000", 2 * FRAME + 2, 1'b1, 16'h0000, 4'b0000);
        run_check("pat_0A00", 2 * FRAME + 2, 1'b1, 16'h0A00, 4'b1000);
    endtask

    task automatic test_midframe_load();
        logic [7:0] es;
        logic [3:0] ed;
        logic ef;
        while ((m_e % FRAME) != DIV + 1) cyc(1'b1, 1'b0, 16'h0, 4'h0, es, ed, ef);
        run_check("midload_5678", 2 * FRAME, 1'b1, 16'h5678, 4'b0000);
    endtask

    task automatic test_enable_drop();
        logic [7:0] es;
        logic [3:0] ed;
        logic ef;
        while ((m_e % DIV) != 2) cyc(1'b1, 1'b0, 16'h0, 4'h0, es, ed, ef);
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b0, 16'h0, 4'h0, es, ed, ef);
            n_vec++;
            if (seg_out !== es || dig_sel !== ed || frame_done !== ef ||
                seg_al !== ~es || dig_al !== ~ed || fd_al !== ef) begin
                n_err++;
                $display("FAIL en_drop cyc %0d: got seg=%h dig=%b fd=%b al=%h/%b, want seg=%h dig=%b fd=%b",
                         k, seg_out, dig_sel, frame_done, seg_al, dig_al, es, ed, ef);
            end
        end
        run_check("en_resume", FRAME + 4, 1'b0, 16'h0, 4'h0);
    endtask

    task automatic test_active_low();
        logic [7:0] es;
        logic [3:0] ed;
        logic ef;
        run_check("al_8888", 2 * FRAME, 1'b1, 16'h8888, 4'b1111);
        for (int k = 0; k < FRAME; k++) begin
            cyc(1'b1, 1'b0, 16'h0, 4'h0, es, ed, ef);
            n_vec++;
            if (seg_al !== 8'h00 || $countones(~dig_al) != 1) begin
                n_err++;
                $display("FAIL al_all_lit cyc %0d: got seg=%h dig=%b, want seg=00 and one digit low",
                         k, seg_al, dig_al);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] es;
        logic [3:0] ed;
        logic ef;
        logic en, ld;
        for (int k = 0; k < 400; k++) begin
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 11) == 0);
            cyc(en, ld, 16'($urandom), 4'($urandom), es, ed, ef);
            n_vec++;
            if (seg_out !== es || dig_sel !== ed || frame_done !== ef ||
                seg_al !== ~es || dig_al !== ~ed || fd_al !== ef) begin
                n_err++;
                $display("FAIL random cyc %0d: got seg=%h dig=%b fd=%b al=%h/%b, want seg=%h dig=%b fd=%b",
                         k, seg_out, dig_sel, frame_done, seg_al, dig_al, es, ed, ef);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] es;
        logic [3:0] ed;
        logic ef;
        int first;
        while ((m_e % FRAME) != 2) cyc(1'b1, 1'b0, 16'h0, 4'h0, es, ed, ef);
        // Pending shadow value that the reset must discard.
        cyc(1'b1, 1'b1, 16'h9999, 4'b1111, es, ed, ef);
        cyc(1'b1, 1'b0, 16'h0, 4'h0, es, ed, ef);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (seg_out !== 8'h00 || dig_sel !== 4'h0 || frame_done !== 1'b0 ||
            seg_al !== 8'hFF || dig_al !== 4'hF) begin
            n_err++;
            $display("FAIL async_reset: got seg=%h dig=%b fd=%b al=%h/%b, want 00 0000 0 FF/1111",
                     seg_out, dig_sel, frame_done, seg_al, dig_al);
        end
        enable = 1'b0;
        load   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        first = 0;
        for (int k = 1; k <= FRAME + 6; k++) begin
            cyc(1'b1, 1'b0, 16'h0, 4'h0, es, ed, ef);
            n_vec++;
            if (seg_out !== es || dig_sel !== ed || frame_done !== ef ||
                seg_al !== ~es || dig_al !== ~ed || fd_al !== ef) begin
                n_err++;
                $display("FAIL post_reset cyc %0d: got seg=%h dig=%b fd=%b al=%h/%b, want seg=%h dig=%b fd=%b",
                         k, seg_out, dig_sel, frame_done, seg_al, dig_al, es, ed, ef);
            end
            if (frame_done === 1'b1 && first == 0) first = k;
        end
        n_vec++;
        if (first != FRAME) begin
            n_err++;
            $display("FAIL first_frame_done: got edge %0d, want edge %0d", first, FRAME);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_patterns();
        test_midframe_load();
        test_enable_drop();
        test_active_low();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, the number of multiplexed digits (legal range 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, the clock cycles each digit is driven (legal range >= 2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 0; when 1, seg_out and dig_sel are inverted at the output register.
REQ-004 SHALL have parameter BLANK_LZ, default 1; when 1, leading-zero blanking is enabled.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 enable  in  1  scan enable; 0 blanks the display and freezes the scan.
REQ-008 load  in  1  capture strobe for bcd_in and dp_in.
REQ-009 bcd_in  in  4*N_DIGITS  packed BCD; nibble i drives digit i; digit 0 is least significant.
REQ-010 dp_in  in  N_DIGITS  decimal-point request per digit.
REQ-011 seg_out  out  8  bit 7 = dp; bits 6..0 = segments a..g, with a in bit 6; 1 = lit before ACTIVE_LOW inversion.
REQ-012 dig_sel  out  N_DIGITS  one-hot digit enable; bit i = digit i.
REQ-013 frame_done  out  1  one-cycle pulse at each frame boundary.

Function
REQ-014 SHALL decode nibbles as 0=0x7E, 1=0x30, 2=0x6D, 3=0x79, 4=0x33, 5=0x5B, 6=0x5F, 7=0x72, 8=0x7F, 9=0x73 on bits 6..0.
REQ-015 SHALL decode any nibble 0xA..0xF as 0x4F ('E').
REQ-016 SHALL capture bcd_in and dp_in into a shadow register on every clk edge where load=1, whether or not enable is high.
REQ-017 SHALL keep a divider counter that runs 0..REFRESH_DIV-1 while enable=1; tick is asserted when count = REFRESH_DIV-1, after which the counter wraps to 0.
REQ-018 SHALL advance the scan index on tick from 0 to N_DIGITS-1, wrapping to 0.
REQ-019 SHALL treat a wrap from N_DIGITS-1 to 0 as the frame boundary: frame_done = 1 for exactly that cycle, and the display register loads the shadow register on that edge.
REQ-020 SHALL, when load=1 coincides with a frame-boundary edge, load bcd_in/dp_in directly into the display register; the shown value never mixes old and new digits within one frame.
REQ-021 SHALL, with BLANK_LZ=1, blank bits 6..0 of digit i (i>0) when digit i and all higher digits are 0; digit 0 is never blanked; dp is unaffected by blanking.
REQ-022 SHALL register seg_out and dig_sel, and both SHALL reflect the current scan index with exactly 1 cycle latency.
REQ-023 SHALL, when enable=0, hold the divider and scan index, force seg_out and dig_sel to off on the next edge, and hold frame_done at 0.
REQ-024 SHALL, when enable returns to 1, resume from the held count and index without an extra frame_done.
REQ-025 SHALL have dig_sel either all-off or exactly one-hot (before inversion) at every cycle.

Reset
REQ-026 SHALL, while rst_n=0, immediately clear the counter, index, shadow, display and frame_done to 0, set seg_out to off (0x00, or 0xFF if ACTIVE_LOW) and set dig_sel to off (all 0, or all 1 if ACTIVE_LOW).
REQ-027 SHALL, on reset asserted mid-frame, discard any pending shadow value; after release, digit 0 is scanned first and shows the display register, which is 0.

Verification (N_DIGITS=4, REFRESH_DIV=4, BLANK_LZ=1, ACTIVE_LOW=0 unless stated)
REQ-028 Reset, enable=1, load 0x1234 with dp_in=0 -> after the first frame_done, the scan sequence is dig_sel 0001/0010/0100/1000 with seg_out 0x33/0x79/0x6D/0x30, each held 4 cycles.
REQ-029 Load 0x0070 -> digits 3,2 = 0x00, digit 1 = 0x72, digit 0 = 0x7E; load 0x0000 -> only digit 0 lit, at 0x7E; load 0x0A00 with dp_in=4'b1000 -> digit 3 = 0x80, digit 2 = 0x4F.
REQ-030 Load 0x5678 while digit 1 is being driven -> digits 2,3 of the current frame still show the old value; the new value appears starting with digit 0 after frame_done.
REQ-031 Drop enable for 10 cycles mid-digit -> seg_out=0x00 and dig_sel=0000 from the next edge, no frame_done; on re-enable, the same digit resumes for its remaining cycles.
REQ-032 ACTIVE_LOW=1, reset -> seg_out=0xFF, dig_sel=1111; load 0x8888 with dp_in=4'b1111 -> seg_out=0x00 on every digit.
REQ-033 Assert rst_n=0 asynchronously mid-frame, between clk edges -> outputs go to the off state without a clock edge; after release, frame_done first pulses exactly 16 cycles after the first enabled edge.
